// File: rtl/mips_trace_buffer.sv
// Retirement trace FIFO: captures {PC+4, IR} per retired instruction and streams
// each entry as two 32-bit words over a valid/ready interface.
module mips_trace_buffer #(
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  logic          clear,
    input  logic          wb_valid,
    input  logic [31:0]   wb_pc_plus4,
    input  logic [31:0]   wb_instruction,
    output logic          trace_valid,
    input  logic          trace_ready,
    output logic [31:0]   trace_data,
    output logic          trace_last,
    output logic [AW:0]   count,
    output logic          overflow,
    output logic [15:0]   drop_count
);

    typedef enum logic [1:0] {IDLE, PC_WORD, IR_WORD} state_t;

    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);

    state_t          state, state_nxt;
    logic [31:0]     pc_mem [DEPTH];
    logic [31:0]     ir_mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic            retire, push, pop, drop;

    // A full FIFO still accepts a retirement when the head leaves on the same edge.
    assign retire = enable && wb_valid && !clear;
    assign pop    = (state == IR_WORD) && trace_ready && !clear;
    assign push   = retire && ((count != FULL_COUNT) || pop);
    assign drop   = retire && (count == FULL_COUNT) && !pop;

    // NOTE: the storage array has no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr] <= wb_pc_plus4;
            ir_mem[wr_ptr] <= wb_instruction;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (count != '0) state_nxt = PC_WORD;
                PC_WORD: if (trace_ready) state_nxt = IR_WORD;
                IR_WORD: if (trace_ready)
                             state_nxt = ((count > ONE_COUNT) || push) ? PC_WORD : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        trace_valid = 1'b0;
        trace_last  = 1'b0;
        trace_data  = '0;
        case (state)
            PC_WORD: begin
                trace_valid = 1'b1;
                trace_data  = pc_mem[rd_ptr];
            end
            IR_WORD: begin
                trace_valid = 1'b1;
                trace_last  = 1'b1;
                trace_data  = ir_mem[rd_ptr];
            end
            default: ;
        endcase
    end

endmodule

// File: doc/mips_trace_buffer.md
MIPS_TRACE_BUFFER -- requirements
Module: mips_trace_buffer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in retired-instruction entries; SHALL be a power of two, 2 to 64.
REQ-002 Parameter AW, default log2(DEPTH), pointer width; SHALL be derived from DEPTH and not set independently.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 enable  input  1  capture enable; 0 = wb_valid ignored.
REQ-006 clear  input  1  synchronous flush of FIFO, flags and counter.
REQ-007 wb_valid  input  1  one instruction retires this cycle (MEM/WB stage).
REQ-008 wb_pc_plus4  input  32  PC+4 of the retiring instruction.
REQ-009 wb_instruction  input  32  IR of the retiring instruction.
REQ-010 trace_valid  output  1  trace_data holds a valid word.
REQ-011 trace_ready  input  1  consumer accepts the word.
REQ-012 trace_data  output  32  trace word: PC+4 word, then IR word.
REQ-013 trace_last  output  1  high on the IR word (second word of an entry).
REQ-014 count  output  AW+1  number of occupied FIFO entries, 0..DEPTH.
REQ-015 overflow  output  1  sticky: at least one retirement was dropped.
REQ-016 drop_count  output  16  number of dropped retirements, saturating.

Function
REQ-017 Push: on an edge with enable=1, wb_valid=1, clear=0 and (count<DEPTH or pop this edge), the entry {wb_pc_plus4, wb_instruction} SHALL be written at the tail.
REQ-018 Drop: on an edge with enable=1, wb_valid=1, clear=0, count=DEPTH and no pop, the entry SHALL be discarded, overflow set to 1, and drop_count incremented, saturating at 16'hFFFF.
REQ-019 Output FSM states: IDLE, PC_WORD, IR_WORD.
REQ-020 IDLE -> PC_WORD at the edge where count>0 is observed; otherwise remain in IDLE.
REQ-021 PC_WORD -> IR_WORD on trace_valid && trace_ready.
REQ-022 IR_WORD on handshake: pop the head; go to PC_WORD if the post-pop count>0 (including a same-edge push), else go to IDLE.
REQ-023 trace_valid SHALL be 1 exactly in PC_WORD and IR_WORD.
REQ-024 trace_data SHALL equal the head PC+4 in PC_WORD, the head IR in IR_WORD, and 0 in IDLE.
REQ-025 trace_last SHALL be 1 only in IR_WORD.
REQ-026 While trace_valid=1 and trace_ready=0, trace_data and trace_last SHALL hold stable.
REQ-027 Latency: an entry pushed into an empty FIFO at edge N SHALL present trace_valid=1 after edge N+1.
REQ-028 Throughput: with trace_ready held at 1 and the FIFO non-empty, the block SHALL deliver one word per cycle with no IDLE bubble between entries.
REQ-029 A simultaneous push and pop SHALL leave count unchanged, including at count=DEPTH.
REQ-030 Pointers SHALL wrap modulo DEPTH, and entry order SHALL be strictly FIFO.
REQ-031 Clear at an edge SHALL empty the FIFO, set count=0, overflow=0, drop_count=0 and state IDLE.
REQ-032 Clear SHALL take priority over a simultaneous push (not counted as a drop) and over a pop.
REQ-033 With enable=0, wb_valid SHALL have no effect; draining SHALL continue.

Reset
REQ-034 While reset=0, the block SHALL asynchronously force state IDLE, pointers 0, count=0, trace_valid=0, trace_data=0, trace_last=0, overflow=0, drop_count=0.
REQ-035 Reset asserted mid-entry (PC_WORD/IR_WORD) SHALL abandon the entry; no partial entry SHALL be emitted after release.
REQ-036 FIFO storage contents need not be reset.
REQ-037 The first push SHALL be accepted at the first rising edge after reset deasserts.

Verification
REQ-038 Single retire, PC+4=0x00000004, IR=0x20080005, ready=1 -> after edge N+1, valid=1 with data 0x00000004, last=0; next cycle data 0x20080005, last=1; then IDLE, count=0.
REQ-039 DEPTH=8, ready=0, 10 consecutive retires -> count=8, overflow=1, drop_count=2; draining returns the first 8 entries in order.
REQ-040 FIFO full, ready=1 in IR_WORD, wb_valid=1 same edge -> push accepted, count stays 8, drop_count unchanged.
REQ-041 ready toggling 1,0,0,1 during an entry -> trace_data stable while stalled; exactly two words emitted per entry.
REQ-042 3 entries queued, clear=1 together with wb_valid=1 -> count=0, overflow=0, drop_count=0, trace_valid=0 next cycle.
REQ-043 reset=0 pulsed while in IR_WORD with 2 entries queued -> all outputs 0 immediately; no words emitted after release until a new push.
